// File: rtl/uart_pkg.sv
// Shared UART constants and receive FSM encoding.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int DELAY_FRAMES   = 234;
  localparam int DATA_BITS      = 8;
  localparam int STOP_BITS      = 1;
  localparam int ARRAY_WORDS    = 100;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_word_receiver_if.sv
// Receive-side result bundle: byte, word and error strobes.
// master drives results, slave consumes them.
interface uart_word_receiver_if #(
  parameter int IDX_W = 7
);

  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic [31:0]      word_data;
  logic [IDX_W-1:0] word_index;
  logic             word_valid;
  logic             frame_done;
  logic             framing_error;

  modport master (
    output rx_byte,
    output byte_valid,
    output word_data,
    output word_index,
    output word_valid,
    output frame_done,
    output framing_error
  );

  modport slave (
    input rx_byte,
    input byte_valid,
    input word_data,
    input word_index,
    input word_valid,
    input frame_done,
    input framing_error
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-FF synchroniser, mid-bit sampling FSM,
// byte strobe and framing-error strobe.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = uart_pkg::DELAY_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       framing_error
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DELAY_FRAMES);
  localparam logic [CNT_W-1:0] HALF =
    CNT_W'((DELAY_FRAMES + 1) / 2);
  localparam logic [2:0] LAST_BIT =
    3'(DATA_BITS - 1);

  logic             sync1, sync2;
  rx_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       shift, shift_n;
  logic [7:0]       byte_n;
  logic             bv_n, fe_n;

  // Flops reset high so a released reset never looks like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_cnt       <= '0;
      shift         <= '0;
      rx_byte       <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_cnt       <= bit_n;
      shift         <= shift_n;
      rx_byte       <= byte_n;
      byte_valid    <= bv_n;
      framing_error <= fe_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    byte_n  = rx_byte;
    bv_n    = 1'b0;
    fe_n    = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (!sync2) state_n = START;
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = sync2 ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          shift_n = {sync2, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == LAST_BIT) state_n = STOP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == LAST) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (sync2) begin
            byte_n = shift;
            bv_n   = 1'b1;
          end else begin
            fe_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_word_receiver.sv
// UART receiver packing bytes little-endian into indexed
// 32-bit words for array loading.
module uart_word_receiver
  import uart_pkg::*;
#(
  parameter int DELAY_FRAMES = uart_pkg::DELAY_FRAMES,
  parameter int WORDS        = ARRAY_WORDS,
  parameter int IDX_W        = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic uart_rx,
  input  logic clear,
  uart_word_receiver_if.master rx_if
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(WORDS - 1);
  localparam logic [1:0] LAST_LANE =
    2'(BYTES_PER_WORD - 1);

  logic [7:0]       rx_byte;
  logic             byte_valid;
  logic             framing_error;
  logic [1:0]       lane;
  logic [23:0]      acc;
  logic [IDX_W-1:0] idx, idx_q;
  logic [31:0]      word_q;
  logic             word_fire;

  uart_rx_byte #(
    .DELAY_FRAMES (DELAY_FRAMES)
  ) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .uart_rx       (uart_rx),
    .rx_byte       (rx_byte),
    .byte_valid    (byte_valid),
    .framing_error (framing_error)
  );

  assign word_fire = byte_valid && (lane == LAST_LANE)
                     && !clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane   <= '0;
      acc    <= '0;
      idx    <= '0;
      idx_q  <= '0;
      word_q <= '0;
    end else if (clear) begin
      lane <= '0;
      idx  <= '0;
    end else if (framing_error) begin
      lane <= '0;
    end else if (byte_valid) begin
      if (lane == LAST_LANE) begin
        word_q <= {rx_byte, acc};
        idx_q  <= idx;
        idx    <= (idx == LAST_IDX) ? '0
                  : idx + IDX_W'(1);
        lane   <= '0;
      end else begin
        unique case (lane)
          2'd0:    acc[7:0]   <= rx_byte;
          2'd1:    acc[15:8]  <= rx_byte;
          default: acc[23:16] <= rx_byte;
        endcase
        lane <= lane + 2'd1;
      end
    end
  end

  // Completed word is shown on the pulse itself, then held
  assign rx_if.rx_byte       = rx_byte;
  assign rx_if.byte_valid    = byte_valid;
  assign rx_if.framing_error = framing_error;
  assign rx_if.word_valid    = word_fire;
  assign rx_if.word_data     = word_fire ? {rx_byte, acc}
                                         : word_q;
  assign rx_if.word_index    = word_fire ? idx : idx_q;
  assign rx_if.frame_done    = word_fire && (idx == LAST_IDX);

endmodule

// File: tb/tb_uart_word_receiver.sv
// Self-checking bench for uart_word_receiver.
// Short bit period keeps the full-frame test fast.
module tb_uart_word_receiver;

  localparam int DF    = 11;
  localparam int BIT   = DF + 1;
  localparam int HALF  = BIT / 2;
  localparam int WORDS = 100;
  localparam int IDX_W = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic uart_rx;
  logic clear;

  uart_word_receiver_if #(.IDX_W(IDX_W)) u_if ();

  uart_word_receiver #(
    .DELAY_FRAMES (DF),
    .WORDS        (WORDS),
    .IDX_W        (IDX_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .uart_rx (uart_rx),
    .clear   (clear),
    .rx_if   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b;
    bit          wv;
    logic [31:0] d;
    int          idx;
    bit          fd;
  } ev_t;

  ev_t        exq[$];
  ev_t        ce;
  logic [7:0] wb[4];
  int         k;
  int         exp_fe;
  int         tests;
  int         fails;
  int         fd_seen;
  int         wv_seen;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: byte count k since last restart gives lane and index
  function automatic void push(input logic [7:0] b,
                               input bit clr);
    ev_t e;
    e.b = b; e.wv = 0; e.d = '0; e.idx = 0; e.fd = 0;
    if (clr) begin
      k = 0;
    end else begin
      wb[k % 4] = b;
      if (k % 4 == 3) begin
        e.wv  = 1;
        e.d   = {wb[3], wb[2], wb[1], wb[0]};
        e.idx = (k / 4) % WORDS;
        e.fd  = (e.idx == WORDS - 1);
      end
      k++;
    end
    exq.push_back(e);
  endfunction

  task automatic send_byte(input logic [7:0] b,
                           input bit stop_ok);
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    if (stop_ok) begin
      uart_rx = 1'b1;
      repeat (BIT) @(negedge clk);
    end else begin
      uart_rx = 1'b0;
      repeat (HALF + 2) @(negedge clk);
      uart_rx = 1'b1;
      repeat (BIT - HALF - 2) @(negedge clk);
    end
  endtask

  task automatic good(input logic [7:0] b);
    push(b, 0);
    send_byte(b, 1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) good(w[8*i +: 8]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (u_if.framing_error) begin
        if (exp_fe > 0) begin
          exp_fe--;
          tests++;
        end else begin
          check("framing_error_unexpected", 1, 0);
        end
      end
      if (u_if.byte_valid) begin
        if (exq.size() == 0) begin
          check("byte_valid_unexpected", 1, 0);
        end else begin
          ce = exq.pop_front();
          check("rx_byte", 32'(u_if.rx_byte), 32'(ce.b));
          check("word_valid", 32'(u_if.word_valid),
                32'(ce.wv));
          if (ce.wv) begin
            check("word_data", u_if.word_data, ce.d);
            check("word_index", 32'(u_if.word_index),
                  32'(ce.idx));
            check("frame_done", 32'(u_if.frame_done),
                  32'(ce.fd));
          end
        end
      end else begin
        check("word_pulse_without_byte",
              {30'd0, u_if.word_valid, u_if.frame_done}, 0);
      end
      if (u_if.frame_done) fd_seen++;
      if (u_if.word_valid) wv_seen++;
    end
  end

  initial begin
    tests = 0; fails = 0; k = 0; exp_fe = 0;
    fd_seen = 0; wv_seen = 0;
    rst_n = 1'b0; uart_rx = 1'b1; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle line: no pulses, outputs at reset values
    repeat (5000) @(negedge clk);
    check("idle_rx_byte", 32'(u_if.rx_byte), 0);
    check("idle_word_data", u_if.word_data, 0);
    check("idle_word_index", 32'(u_if.word_index), 0);
    check("idle_pulses", {28'd0, u_if.byte_valid,
          u_if.word_valid, u_if.frame_done,
          u_if.framing_error}, 0);

    // First word
    good(8'h78); good(8'h56); good(8'h34); good(8'h12);
    check("w0_data_lit", u_if.word_data, 32'h12345678);
    check("w0_index_lit", 32'(u_if.word_index), 0);

    // Restart, then a full frame plus one wrapped word
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    k = 0;
    wv_seen = 0;
    for (int i = 0; i < WORDS; i++)
      send_word(32'(i) * 32'h01000001);
    check("frame_words_lit", 32'(wv_seen), 100);
    check("frame_done_lit", 32'(fd_seen), 1);
    check("w99_data_lit", u_if.word_data, 32'h63000063);
    check("w99_index_lit", 32'(u_if.word_index), 99);
    send_word(32'h64000064);
    check("wrap_index_lit", 32'(u_if.word_index), 0);
    check("wrap_data_lit", u_if.word_data, 32'h64000064);
    check("wrap_no_done_lit", 32'(fd_seen), 1);

    // Short low glitch is rejected silently
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (200) @(negedge clk);

    // Framing error drops partial word, index kept
    good(8'h11); good(8'h22);
    exp_fe++;
    k = k - (k % 4);
    send_byte(8'hA5, 0);
    repeat (2 * BIT) @(negedge clk);
    check("ferr_consumed", 32'(exp_fe), 0);
    send_word(32'hDDCCBBAA);
    check("ferr_word_lit", u_if.word_data, 32'hDDCCBBAA);
    check("ferr_index_lit", 32'(u_if.word_index), 1);

    // clear coincident with 4th byte's strobe
    good(8'h01); good(8'h02); good(8'h03);
    push(8'h04, 1);
    fork
      send_byte(8'h04, 1);
      begin
        bit got;
        got = 0;
        for (int i = 0; i < 12 * BIT && !got; i++) begin
          @(posedge clk);
          #1;
          if (u_if.byte_valid) got = 1;
        end
        if (got) begin
          clear = 1'b1;
          @(posedge clk);
          #1 clear = 1'b0;
        end else begin
          check("clear_wait_timeout", 0, 1);
        end
      end
    join
    check("clear_hold_data", u_if.word_data, 32'hDDCCBBAA);

    // Reset in the middle of a frame's data bits
    uart_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_word_data", u_if.word_data, 0);
    check("rst_word_index", 32'(u_if.word_index), 0);
    check("rst_rx_byte", 32'(u_if.rx_byte), 0);
    check("rst_pulses", {28'd0, u_if.byte_valid,
          u_if.word_valid, u_if.frame_done,
          u_if.framing_error}, 0);
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    check("rst_queue_empty", 32'(exq.size()), 0);
    repeat (30) @(negedge clk);
    send_word(32'hDEADBEEF);
    check("post_rst_data_lit", u_if.word_data, 32'hDEADBEEF);
    check("post_rst_index_lit", 32'(u_if.word_index), 0);

    repeat (3 * BIT) @(negedge clk);
    check("queue_drained", 32'(exq.size()), 0);
    check("fe_drained", 32'(exp_fe), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_word_receiver.md
Name: uart_word_receiver

Overview:
- UART receive path, the counterpart of the existing UART transmitter and array transmitter.
- Deserialises 8N1 bytes from the uart_rx pin and packs them little-endian into 32-bit words, byte 0 → bits 7:0, matching the transmit byte order.
- Emits each word with its array index so the top level can load u_arr/du_arr initial conditions from the host.
- Word index wraps at WORDS and flags frame completion.

Parameters:
- DELAY_FRAMES, 234: bit period is DELAY_FRAMES+1 clocks (235 at 27 MHz ≈ 115200 baud), identical to the transmitter.
- WORDS, 100: words per frame (array length).
- IDX_W, 7: width of word_index; must satisfy 2^IDX_W ≥ WORDS.

Ports:
- clk  in  1  system clock (27 MHz).
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- uart_rx  in  1  serial input, asynchronous to clk, idle high.
- clear  in  1  synchronous restart of assembly at word 0, byte lane 0.
- rx_byte  out  8  last received byte.
- byte_valid  out  1  one-clock pulse, rx_byte valid.
- word_data  out  32  assembled word.
- word_index  out  IDX_W  index of word_data, 0..WORDS-1.
- word_valid  out  1  one-clock pulse, word_data/word_index valid.
- frame_done  out  1  one-clock pulse coincident with word_valid for index WORDS-1.
- framing_error  out  1  one-clock pulse, stop bit sampled low.

Behaviour:
- Reset values:
  - All pulse outputs 0; rx_byte, word_data, word_index 0.
  - Internal byte lane 0; FSM in IDLE.
  - Synchroniser flops reset to 1, so no false start after reset.
- Input synchroniser: 2-FF on uart_rx; the FSM uses only the synchronised signal.
- FSM states:
  - IDLE: counter cleared. Synchronised rx = 0 → START.
  - START: count to (DELAY_FRAMES+1)/2 = 117, then sample. Low → DATA with bit counter 0 and clock counter 0. High → IDLE (glitch rejected, nothing reported).
  - DATA: sample every DELAY_FRAMES+1 clocks, i.e. mid-bit. Shift LSB first. After the 8th sample → STOP.
  - STOP: sample after one more bit period. If 1: rx_byte updated and byte_valid pulsed the next clock. If 0: framing_error pulsed, byte discarded. Either way → IDLE the next clock, so back-to-back frames (next start edge immediately after stop) are received.
- Word assembly:
  - On each byte_valid the byte is written into lane L: bits 8L+7:8L.
  - At L=3: word_valid pulses on the same clock as byte_valid for that byte, with the complete word; L → 0; word_index advances after the pulse.
  - Index at WORDS-1 wraps to 0, and frame_done pulses with that word_valid.
  - word_data/word_index hold their values until the next word_valid.
- Framing error: partial word discarded (L → 0). word_index unchanged.
- clear:
  - Sets L=0 and index=0 and suppresses any word_valid/frame_done on that clock.
  - clear has priority over a simultaneous byte_valid; that byte is dropped from assembly but still reported on rx_byte/byte_valid.
  - clear does not disturb the bit-level FSM.
- Latency: stop-bit sample → byte_valid/word_valid = 1 clock. Start edge on pin → byte_valid ≈ 2 + 117 + 9×235 + 1 clocks.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the receiver waits for a fresh falling edge; the remaining bits of the interrupted frame may be misread, with the stop check catching most cases.

Decomposition:
- Shared package uart_pkg:
  - DELAY_FRAMES default 234.
  - Data bits 8, stop bits 1.
  - Rx FSM state encoding (IDLE, START, DATA, STOP).
  - ARRAY_WORDS = 100 and BYTES_PER_WORD = 4, shared with the transmitter side.
- One sub-module uart_rx_byte:
  - Contains the synchroniser, FSM, rx_byte/byte_valid and framing_error.
  - The top of this block adds lane/index assembly only.

Test Plan:
- Reset, then idle line high for 5000 clocks → no pulses; outputs all 0.
- Bytes 0x78,0x56,0x34,0x12 sent back-to-back at 235 clk/bit → four byte_valid pulses with those values. One word_valid with word_data=0x12345678, word_index=0.
- 400 bytes encoding words 0..99 with value i×0x01000001 → 100 word_valid pulses with matching indices. frame_done only with index 99. 401st–404th bytes → word_index wraps to 0.
- Low glitch of 50 clocks on idle line → back to IDLE; no byte_valid, no framing_error.
- Byte 0xA5 with stop bit forced 0 after two good bytes → framing_error pulse, no byte_valid. Next four good bytes form word_index unchanged with correct data.
- clear asserted on the same clock as the 4th byte's byte_valid → no word_valid. Then rst_n pulled low mid-DATA of the next frame → all outputs 0 asynchronously; clean frame after release received correctly at index 0.
